// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit. A single-cycle start request either moves a
// value straight into HI or LO (mthi/mtlo), or launches a multi-cycle
// mult/multu/div/divu. That operation holds busy for a fixed number of
// cycles and then writes HI/LO with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; mthi/mtlo complete here in one edge
// BUSY  | operands latched, cnt counts down; results land at cnt 1->0

module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;   // op[1:0] of the launched op: bit1 = divide, bit0 = unsigned
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign busy = (state == BUSY);

    // Shared datapath: one 64-bit multiplier (sign- or zero-extended inputs)
    // and one unsigned divider on magnitudes, with signs restored afterwards.
    // Working on magnitudes makes 0x80000000 / -1 fall out as 0x80000000 rem 0
    // without a special case.
    always_comb begin
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_q[31];
        b_neg     = is_signed & b_q[31];

        mul_a   = {{32{a_neg}}, a_q};
        mul_b   = {{32{b_neg}}, b_q};
        product = mul_a * mul_b;

        num      = a_neg ? (~a_q + 32'd1) : a_q;
        den      = b_neg ? (~b_q + 32'd1) : b_q;
        den_safe = (den == 32'd0) ? 32'd1 : den;
        q_mag    = num / den_safe;
        r_mag    = num % den_safe;
        quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Control FSM, countdown timer and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'b00;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_q   <= rs_data;
                                b_q   <= rt_data;
                                op_q  <= op[1:0];
                                cnt   <= MULT_LOAD;
                                state <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q   <= rs_data;
                                b_q   <= rt_data;
                                op_q  <= op[1:0];
                                cnt   <= DIV_LOAD;
                                state <= BUSY;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        if (!op_q[1]) begin
                            hi <= product[63:32];
                            lo <= product[31:0];
                        end else if (b_q != 32'd0) begin
                            // Divide by zero still takes the full time but leaves HI/LO alone.
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use a single clock: reset reset, synchronous, active-high; clock clk.
REQ-002 MULT_CYCLES, default 5, SHALL be the busy length in cycles of mult/multu.
REQ-003 DIV_CYCLES, default 10, SHALL be the busy length in cycles of div/divu.
REQ-004 The ports SHALL be, one per line:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  request qualifier, sampled at posedge clk
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved
- rs_data  input  32  operand A, taken from register-file rdata1
- rt_data  input  32  operand B, taken from register-file rdata2
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO take a mult/div result
- hi  output  32  HI register
- lo  output  32  LO register

Function
REQ-005 The control SHALL be a two-state FSM, IDLE and BUSY, plus a down-counter `cnt` (4 bits minimum).
REQ-006 In IDLE, a mult/multu request with start=1 at edge k SHALL latch rs_data/rt_data, load cnt=MULT_CYCLES, and enter BUSY.
REQ-007 In IDLE, a div/divu request with start=1 at edge k SHALL latch the operands, load cnt=DIV_CYCLES, and enter BUSY.
REQ-008 busy SHALL equal (state==BUSY): high for exactly N cycles after edge k, low again after edge k+N.
REQ-009 In BUSY, cnt SHALL decrement at every edge.
REQ-010 At the edge where cnt goes 1->0, HI/LO SHALL be written, state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-011 hi/lo SHALL hold their old values for the whole BUSY period; results become visible only after edge k+N.
REQ-012 mult SHALL produce the signed 64-bit product of the latched operands, {HI,LO}=A*B.
REQ-013 multu SHALL produce the unsigned 64-bit product, {HI,LO}=A*B.
REQ-014 div SHALL be signed: LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend.
REQ-015 divu SHALL be unsigned: LO=A/B, HI=A%B.
REQ-016 For signed div of 0x80000000 by 0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0x00000000.
REQ-017 For div/divu with B==0, the block SHALL still go BUSY for DIV_CYCLES and pulse done, and SHALL leave HI and LO unchanged.
REQ-018 mthi with start=1 in IDLE SHALL load hi<=rs_data at that edge without entering BUSY; done SHALL stay 0.
REQ-019 mtlo with start=1 in IDLE SHALL load lo<=rs_data at that edge without entering BUSY; done SHALL stay 0.
REQ-020 Any start while BUSY SHALL be ignored, including mthi/mtlo; changes on rs_data/rt_data during BUSY SHALL NOT affect the result.
REQ-021 Reserved op codes, and any op with start=0, SHALL cause no state change.
REQ-022 A new start in the cycle where done=1 SHALL be accepted normally, so back-to-back operations are allowed.
REQ-023 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-024 With reset=1 at a posedge, the block SHALL set state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0.
REQ-025 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL write nothing and produce no done pulse.
REQ-026 After reset deasserts, the first edge with start=1 SHALL be accepted.

Verification
REQ-027 The bench SHALL cover mult of rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-028 The bench SHALL cover multu of 0xFFFFFFFF by 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
REQ-029 The bench SHALL cover div of -7 (0xFFFFFFF9) by 2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; also divu of 7 by 0 with hi=0x11, lo=0x22 preset -> values unchanged and done pulses.
REQ-030 The bench SHALL cover mthi with 0x12345678 in IDLE -> hi=0x12345678 next cycle and busy stays 0; the same mthi issued during BUSY -> hi unchanged.
REQ-031 The bench SHALL cover reset asserted at cycle 3 of a div -> busy=0, hi=lo=0, no done pulse, and a following multu 2*3 yields lo=6 after 5 cycles.
REQ-032 The bench SHALL cover signed div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0, and a start issued in the done cycle is accepted.
